ecc_scalar_mul: RTL and testbench
=================================

Name: ecc_scalar_mul

Overview:
- Downstream/controller stage for the lab6 EC point adder. Computes R = k·P on y² = x³ + a·x + b mod prime, all values 6-bit.
- Uses left-to-right double-and-add. Every doubling and addition is issued to the existing point adder over its in_valid/out_valid pulse interface.
- Handles point-at-infinity cases locally; the adder never receives a point at infinity.

Parameters:
- TIMEOUT, 1000, max cycles to wait for an adder response after each request.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  one-cycle start pulse
- in_Px, in_Py  in  6 each  base point P
- in_k  in  6  scalar
- in_prime  in  6  modulus
- in_a  in  6  curve coefficient a
- add_valid  out  1  one-cycle request pulse to the adder
- add_Px, add_Py, add_Qx, add_Qy  out  6 each  adder operands; valid only while add_valid=1, else 0
- add_prime, add_a  out  6 each  forwarded; valid only while add_valid=1, else 0
- add_out_valid  in  1  adder result pulse
- add_Rx, add_Ry  in  6 each  adder result
- out_valid  out  1  one-cycle result pulse
- out_Rx, out_Ry  out  6 each  result; 0 when out_valid=0
- out_inf  out  1  result is point at infinity (then Rx = Ry = 0)
- out_err  out  1  adder timeout occurred

Behaviour:
- Reset:
  - Synchronous reset on a clk edge with rst=1.
  - All outputs go to 0 and the FSM goes to IDLE.
  - Reset mid-operation aborts the job; no out_valid follows it.
- Input capture:
  - On in_valid in IDLE, register P, k, prime and a.
  - in_valid outside IDLE is ignored.
- States: IDLE, SCAN, DBL_REQ, DBL_WAIT, ADD_REQ, ADD_WAIT, DONE.
- SCAN (1 cycle):
  - k=0 → DONE with inf=1.
  - Otherwise set i = index of MSB of k, R = P, inf = 0.
  - If i=0 → DONE; else set j = i−1 → DBL_REQ.
- DBL_REQ (doubling, 1 cycle):
  - If inf=1 or Ry=0: set inf=1 with no adder call, then go to the bit step.
  - Else pulse add_valid with P=Q=R → DBL_WAIT.
- DBL_WAIT:
  - On add_out_valid, latch R = (add_Rx, add_Ry), then go to the bit step.
- Bit step:
  - If k[j]=1 → ADD_REQ.
  - Else, if j=0 → DONE; otherwise decrement j → DBL_REQ.
- ADD_REQ (1 cycle), evaluated in order:
  - If inf=1: R = P, inf = 0, no adder call.
  - Else if Rx = Px and Ry ≠ Py: inf = 1, no adder call.
  - Else pulse add_valid with P=R, Q=Pbase → ADD_WAIT. R = Pbase is sent as-is; the adder performs doubling.
  - After a no-call case, continue as in the bit step without re-testing k[j].
- ADD_WAIT:
  - On add_out_valid, latch R, then continue as in the bit step without re-testing k[j].
- Timeout:
  - Cycles in either WAIT state are counted from the request.
  - If the count reaches TIMEOUT without add_out_valid → DONE with err=1 and outputs Rx = Ry = 0.
  - A late add_out_valid arriving in any non-WAIT state is ignored.
- DONE (1 cycle):
  - out_valid=1 with out_Rx, out_Ry, out_inf, out_err driven → IDLE.
  - A new in_valid is accepted starting the cycle after DONE.
- Adder usage:
  - At most one outstanding request; add_valid is never asserted in a WAIT state.
  - add_out_valid in the same cycle as the timeout-count hit takes priority (result accepted).
- Latency without waits: 1 (capture) + 1 (SCAN) + 2 cycles per adder call + 1 per locally resolved step + 1 (DONE).

Test Plan:
(Curve p=17, a=2, b=2, P=(5,1), order 19. The bench adder model responds after a random 1–20 cycles.)
- k=1 → out_valid with (5,1), inf=0; zero add_valid pulses.
- k=2 → (6,3); exactly one add_valid with P=Q=(5,1).
- k=9 → (7,6); four adder calls producing (6,3), (3,1), (13,7), (7,6) in order.
- k=19 → 18P=(5,16) + P resolved locally: out_inf=1, Rx=Ry=0; exactly five adder calls.
- k=0 → out_inf=1 with no adder calls; latency 3 cycles from in_valid. Also pulse in_valid while busy and confirm it is ignored: one result only.
- Adder stub never responds, TIMEOUT=50, k=2 → out_err=1 exactly 50 cycles after add_valid. Separately, assert rst during DBL_WAIT → no out_valid, outputs 0, and a fresh k=1 job succeeds.

Source files
------------

// File: rtl/ecc_scalar_mul.sv
// ecc_scalar_mul: computes R = k*P on a 6-bit prime-field elliptic curve using
// left-to-right double-and-add. Each doubling or addition is sent to the external
// point adder over a valid/valid pulse handshake. Cases that involve the point at
// infinity are resolved here, so the adder never receives the point at infinity.
module ecc_scalar_mul #(
    parameter int TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [5:0] in_Px,
    input  logic [5:0] in_Py,
    input  logic [5:0] in_k,
    input  logic [5:0] in_prime,
    input  logic [5:0] in_a,
    output logic       add_valid,
    output logic [5:0] add_Px,
    output logic [5:0] add_Py,
    output logic [5:0] add_Qx,
    output logic [5:0] add_Qy,
    output logic [5:0] add_prime,
    output logic [5:0] add_a,
    input  logic       add_out_valid,
    input  logic [5:0] add_Rx,
    input  logic [5:0] add_Ry,
    output logic       out_valid,
    output logic [5:0] out_Rx,
    output logic [5:0] out_Ry,
    output logic       out_inf,
    output logic       out_err
);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DBL_REQ,
        DBL_WAIT,
        ADD_REQ,
        ADD_WAIT,
        DONE
    } state_t;

    // The wait counter holds the number of cycles since the request pulse. The
    // request cycle counts as 1. It is compared against TIMEOUT-1 so that the
    // error report (the DONE cycle) lands exactly TIMEOUT cycles after add_valid.
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    state_t        state;
    logic [5:0]    base_x;
    logic [5:0]    base_y;
    logic [5:0]    k_reg;
    logic [5:0]    prime_reg;
    logic [5:0]    a_reg;
    logic [5:0]    r_x;
    logic [5:0]    r_y;
    logic          r_inf;
    logic          timed_out;
    logic [2:0]    j;
    logic [CW-1:0] wait_cnt;

    logic [7:0]    k_ext;
    logic          bit_set;
    logic          j_last;
    logic [2:0]    k_msb;
    logic          wait_expired;

    // Index of the highest set bit of the scalar. The result is 0 when k is 0,
    // but that case is handled separately in SCAN.
    function automatic logic [2:0] msb_index(input logic [5:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int b = 0; b < 6; b++) begin
            if (v[b]) idx = 3'(b);
        end
        return idx;
    endfunction

    // Scan-position helpers shared by the bit-step decisions.
    always_comb begin
        k_ext        = {2'b00, k_reg};
        bit_set      = k_ext[j];
        j_last       = (j == 3'd0);
        k_msb        = msb_index(k_reg);
        wait_expired = (wait_cnt >= WAIT_LAST);
    end

    // Main controller: this FSM updates the working point and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            base_x    <= 6'd0;
            base_y    <= 6'd0;
            k_reg     <= 6'd0;
            prime_reg <= 6'd0;
            a_reg     <= 6'd0;
            r_x       <= 6'd0;
            r_y       <= 6'd0;
            r_inf     <= 1'b0;
            timed_out <= 1'b0;
            j         <= 3'd0;
            wait_cnt  <= '0;
            add_valid <= 1'b0;
            add_Px    <= 6'd0;
            add_Py    <= 6'd0;
            add_Qx    <= 6'd0;
            add_Qy    <= 6'd0;
            add_prime <= 6'd0;
            add_a     <= 6'd0;
            out_valid <= 1'b0;
            out_Rx    <= 6'd0;
            out_Ry    <= 6'd0;
            out_inf   <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            add_valid <= 1'b0;
            add_Px    <= 6'd0;
            add_Py    <= 6'd0;
            add_Qx    <= 6'd0;
            add_Qy    <= 6'd0;
            add_prime <= 6'd0;
            add_a     <= 6'd0;
            out_valid <= 1'b0;
            out_Rx    <= 6'd0;
            out_Ry    <= 6'd0;
            out_inf   <= 1'b0;
            out_err   <= 1'b0;

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        base_x    <= in_Px;
                        base_y    <= in_Py;
                        k_reg     <= in_k;
                        prime_reg <= in_prime;
                        a_reg     <= in_a;
                        timed_out <= 1'b0;
                        state     <= SCAN;
                    end
                end

                SCAN: begin
                    if (k_reg == 6'd0) begin
                        r_inf <= 1'b1;
                        state <= DONE;
                    end else begin
                        r_x   <= base_x;
                        r_y   <= base_y;
                        r_inf <= 1'b0;
                        if (k_msb == 3'd0) begin
                            state <= DONE;
                        end else begin
                            j     <= k_msb - 3'd1;
                            state <= DBL_REQ;
                        end
                    end
                end

                DBL_REQ: begin
                    if (r_inf || r_y == 6'd0) begin
                        r_inf <= 1'b1;
                        if (bit_set)     state <= ADD_REQ;
                        else if (j_last) state <= DONE;
                        else begin
                            j     <= j - 3'd1;
                            state <= DBL_REQ;
                        end
                    end else begin
                        add_valid <= 1'b1;
                        add_Px    <= r_x;
                        add_Py    <= r_y;
                        add_Qx    <= r_x;
                        add_Qy    <= r_y;
                        add_prime <= prime_reg;
                        add_a     <= a_reg;
                        wait_cnt  <= CW'(1);
                        state     <= DBL_WAIT;
                    end
                end

                DBL_WAIT: begin
                    if (add_out_valid) begin
                        r_x <= add_Rx;
                        r_y <= add_Ry;
                        if (bit_set)     state <= ADD_REQ;
                        else if (j_last) state <= DONE;
                        else begin
                            j     <= j - 3'd1;
                            state <= DBL_REQ;
                        end
                    end else if (wait_expired) begin
                        timed_out <= 1'b1;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end

                ADD_REQ: begin
                    if (r_inf) begin
                        r_x   <= base_x;
                        r_y   <= base_y;
                        r_inf <= 1'b0;
                        if (j_last) state <= DONE;
                        else begin
                            j     <= j - 3'd1;
                            state <= DBL_REQ;
                        end
                    end else if (r_x == base_x && r_y != base_y) begin
                        r_inf <= 1'b1;
                        if (j_last) state <= DONE;
                        else begin
                            j     <= j - 3'd1;
                            state <= DBL_REQ;
                        end
                    end else begin
                        add_valid <= 1'b1;
                        add_Px    <= r_x;
                        add_Py    <= r_y;
                        add_Qx    <= base_x;
                        add_Qy    <= base_y;
                        add_prime <= prime_reg;
                        add_a     <= a_reg;
                        wait_cnt  <= CW'(1);
                        state     <= ADD_WAIT;
                    end
                end

                ADD_WAIT: begin
                    if (add_out_valid) begin
                        r_x <= add_Rx;
                        r_y <= add_Ry;
                        if (j_last) state <= DONE;
                        else begin
                            j     <= j - 3'd1;
                            state <= DBL_REQ;
                        end
                    end else if (wait_expired) begin
                        timed_out <= 1'b1;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end

                DONE: begin
                    out_valid <= 1'b1;
                    if (timed_out) begin
                        out_err <= 1'b1;
                    end else if (r_inf) begin
                        out_inf <= 1'b1;
                    end else begin
                        out_Rx <= r_x;
                        out_Ry <= r_y;
                    end
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_scalar_mul.sv
// tb_ecc_scalar_mul: directed test of the scalar multiplier on y^2 = x^3+2x+2 mod 17
// with P=(5,1). A behavioural adder responds after a random delay, and a
// repeated-addition model provides the expected result of each job.
module tb_ecc_scalar_mul;

    localparam int TIMEOUT = 50;
    localparam int PRIME   = 17;
    localparam int CA      = 2;
    localparam int CB      = 2;
    localparam int BX      = 5;
    localparam int BY      = 1;

    typedef struct {
        bit inf;
        int x;
        int y;
    } pt_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid;
    logic [5:0] in_Px, in_Py, in_k, in_prime, in_a;
    logic       add_valid;
    logic [5:0] add_Px, add_Py, add_Qx, add_Qy, add_prime, add_a;
    logic       add_out_valid;
    logic [5:0] add_Rx, add_Ry;
    logic       out_valid;
    logic [5:0] out_Rx, out_Ry;
    logic       out_inf, out_err;

    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    bit  expect_result = 1'b0;
    int  exp_rx, exp_ry;
    bit  exp_inf, exp_err;
    int  results_seen = 0;
    int  job_base = 0;
    int  start_cyc = 0;
    int  last_out_cyc = 0;
    int  last_req_cyc = 0;
    int  calls = 0;
    bit  stub_mode = 1'b0;
    int  req0_px, req0_py, req0_qx, req0_qy;
    pt_t resq[$];

    ecc_scalar_mul #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in_Px(in_Px), .in_Py(in_Py), .in_k(in_k), .in_prime(in_prime), .in_a(in_a),
        .add_valid(add_valid), .add_Px(add_Px), .add_Py(add_Py), .add_Qx(add_Qx),
        .add_Qy(add_Qy), .add_prime(add_prime), .add_a(add_a),
        .add_out_valid(add_out_valid), .add_Rx(add_Rx), .add_Ry(add_Ry),
        .out_valid(out_valid), .out_Rx(out_Rx), .out_Ry(out_Ry),
        .out_inf(out_inf), .out_err(out_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int md(input int v);
        int r;
        r = v % PRIME;
        if (r < 0) r = r + PRIME;
        return r;
    endfunction

    function automatic int inv(input int v);
        for (int t = 1; t < PRIME; t++) begin
            if (md(v * t) == 1) return t;
        end
        return 0;
    endfunction

    function automatic bit on_curve(input int x, input int y);
        return md(y * y) == md(x * x * x + CA * x + CB);
    endfunction

    // Textbook affine point addition with the point at infinity handled.
    function automatic pt_t pt_add(input pt_t p, input pt_t q);
        pt_t r;
        int  lam;
        r.inf = 1'b0; r.x = 0; r.y = 0;
        if (p.inf) return q;
        if (q.inf) return p;
        if (p.x == q.x && md(p.y + q.y) == 0) begin
            r.inf = 1'b1;
            return r;
        end
        if (p.x == q.x) lam = md((3 * p.x * p.x + CA) * inv(md(2 * p.y)));
        else            lam = md((q.y - p.y) * inv(md(q.x - p.x)));
        r.x = md(lam * lam - p.x - q.x);
        r.y = md(lam * (p.x - r.x) - p.y);
        return r;
    endfunction

    // k*P by plain repeated addition.
    function automatic pt_t pt_mul(input int k);
        pt_t r, b;
        r.inf = 1'b1; r.x = 0; r.y = 0;
        b.inf = 1'b0; b.x = BX; b.y = BY;
        for (int i = 0; i < k; i++) r = pt_add(r, b);
        return r;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int k);
        pt_t e;
        e = pt_mul(k);
        exp_inf = e.inf;
        exp_rx  = e.inf ? 0 : e.x;
        exp_ry  = e.inf ? 0 : e.y;
        exp_err = 1'b0;
        calls   = 0;
        resq.delete();
        @(negedge clk);
        in_k = 6'(k); in_Px = 6'(BX); in_Py = 6'(BY);
        in_prime = 6'(PRIME); in_a = 6'(CA);
        in_valid = 1'b1;
        start_cyc = cyc;
        job_base = results_seen;
        expect_result = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitResult(input int limit);
        int n;
        n = 0;
        while (results_seen == job_base && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput("result_arrived", int'(results_seen != job_base), 1);
        @(negedge clk);
    endtask

    // Compare process: checks every cycle against the current expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_valid) begin
                    results_seen++;
                    last_out_cyc = cyc;
                    if (!expect_result) begin
                        checkOutput("unexpected_out_valid", 1, 0);
                    end else begin
                        checkOutput("out_Rx", int'(out_Rx), exp_rx);
                        checkOutput("out_Ry", int'(out_Ry), exp_ry);
                        checkOutput("out_inf", int'(out_inf), int'(exp_inf));
                        checkOutput("out_err", int'(out_err), int'(exp_err));
                        expect_result = 1'b0;
                    end
                end else begin
                    checkOutput("idle_out_zero", int'(|{out_Rx, out_Ry, out_inf, out_err}), 0);
                end
                if (!add_valid) begin
                    checkOutput("idle_add_zero",
                                int'(|{add_Px, add_Py, add_Qx, add_Qy, add_prime, add_a}), 0);
                end
            end
        end
    end

    // Behavioural point adder with random response delay (silent in stub mode).
    initial begin
        pt_t p, q, r;
        int  d;
        add_out_valid = 1'b0; add_Rx = 6'd0; add_Ry = 6'd0;
        forever begin
            @(negedge clk);
            if (add_valid && !rst) begin
                calls++;
                last_req_cyc = cyc;
                p.inf = 1'b0; p.x = int'(add_Px); p.y = int'(add_Py);
                q.inf = 1'b0; q.x = int'(add_Qx); q.y = int'(add_Qy);
                if (calls == 1) begin
                    req0_px = p.x; req0_py = p.y; req0_qx = q.x; req0_qy = q.y;
                end
                checkOutput("req_on_curve", int'(on_curve(p.x, p.y) && on_curve(q.x, q.y)), 1);
                checkOutput("req_prime", int'(add_prime), PRIME);
                checkOutput("req_a", int'(add_a), CA);
                if (!stub_mode) begin
                    r = pt_add(p, q);
                    resq.push_back(r);
                    d = int'($urandom_range(20, 1));
                    for (int w = 1; w < d; w++) begin
                        @(negedge clk);
                        checkOutput("add_valid_while_waiting", int'(add_valid), 0);
                    end
                    add_Rx = 6'(r.x); add_Ry = 6'(r.y); add_out_valid = 1'b1;
                    @(negedge clk);
                    add_out_valid = 1'b0; add_Rx = 6'd0; add_Ry = 6'd0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        pt_t m;
        int  base;
        in_valid = 1'b0; in_Px = 6'd0; in_Py = 6'd0; in_k = 6'd0;
        in_prime = 6'd0; in_a = 6'd0;
        repeat (3) @(negedge clk);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_add_valid", int'(add_valid), 0);
        checkOutput("rst_out_bits", int'(|{out_Rx, out_Ry, out_inf, out_err}), 0);
        rst = 1'b0;

        // Hand-computed points pin the reference model.
        m = pt_mul(2);  checkOutput("model_2P_x", m.x, 6);  checkOutput("model_2P_y", m.y, 3);
        m = pt_mul(9);  checkOutput("model_9P_x", m.x, 7);  checkOutput("model_9P_y", m.y, 6);
        m = pt_mul(18); checkOutput("model_18P_x", m.x, 5); checkOutput("model_18P_y", m.y, 16);
        m = pt_mul(19); checkOutput("model_19P_inf", int'(m.inf), 1);

        $display("[TB] k=1");
        applyStimulus(1); waitResult(2000);
        checkOutput("k1_Rx_literal", int'(exp_rx), 5);
        checkOutput("k1_calls", calls, 0);

        $display("[TB] k=2");
        applyStimulus(2); waitResult(2000);
        checkOutput("k2_calls", calls, 1);
        checkOutput("k2_req_P", req0_px * 64 + req0_py, BX * 64 + BY);
        checkOutput("k2_req_Q", req0_qx * 64 + req0_qy, BX * 64 + BY);

        $display("[TB] k=9");
        applyStimulus(9); waitResult(2000);
        checkOutput("k9_calls", calls, 4);
        if (resq.size() == 4) begin
            checkOutput("k9_r0", resq[0].x * 64 + resq[0].y, 6 * 64 + 3);
            checkOutput("k9_r1", resq[1].x * 64 + resq[1].y, 3 * 64 + 1);
            checkOutput("k9_r2", resq[2].x * 64 + resq[2].y, 13 * 64 + 7);
            checkOutput("k9_r3", resq[3].x * 64 + resq[3].y, 7 * 64 + 6);
        end else begin
            checkOutput("k9_result_count", resq.size(), 4);
        end

        $display("[TB] k=19");
        applyStimulus(19); waitResult(2000);
        checkOutput("k19_calls", calls, 5);

        $display("[TB] k=0 with busy in_valid");
        exp_inf = 1'b1; exp_rx = 0; exp_ry = 0; exp_err = 1'b0; calls = 0;
        @(negedge clk);
        in_k = 6'd0; in_Px = 6'(BX); in_Py = 6'(BY); in_prime = 6'(PRIME); in_a = 6'(CA);
        in_valid = 1'b1; start_cyc = cyc; job_base = results_seen; expect_result = 1'b1;
        @(negedge clk); in_k = 6'd2;
        @(negedge clk); in_k = 6'd1;
        @(negedge clk); in_valid = 1'b0;
        waitResult(100);
        checkOutput("k0_latency", last_out_cyc - start_cyc, 3);
        repeat (40) @(negedge clk);
        checkOutput("k0_single_result", results_seen - job_base, 1);
        checkOutput("k0_calls", calls, 0);

        $display("[TB] adder timeout");
        stub_mode = 1'b1;
        applyStimulus(2);
        exp_err = 1'b1; exp_inf = 1'b0; exp_rx = 0; exp_ry = 0;
        waitResult(300);
        checkOutput("timeout_latency", last_out_cyc - last_req_cyc, TIMEOUT);
        checkOutput("timeout_calls", calls, 1);

        $display("[TB] reset during DBL_WAIT");
        applyStimulus(2);
        for (int n = 0; n < 50 && calls == 0; n++) @(negedge clk);
        checkOutput("rst_test_req_seen", calls, 1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        expect_result = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_out_valid", int'(out_valid), 0);
        checkOutput("abort_add_valid", int'(add_valid), 0);
        checkOutput("abort_out_bits", int'(|{out_Rx, out_Ry, out_inf, out_err}), 0);
        base = results_seen;
        repeat (TIMEOUT + 30) @(negedge clk);
        checkOutput("abort_no_result", results_seen - base, 0);

        stub_mode = 1'b0;
        applyStimulus(1); waitResult(2000);
        checkOutput("after_rst_calls", calls, 0);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
